// File: rtl/clkdiv_detect_pkg.sv
// Shared definitions for the divided-clock period detector: FSM state
// encoding, ratio_code values and the period-to-ratio mapping.
package clkdiv_detect_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam logic [1:0] RATIO_UNKNOWN = 2'd0;
   localparam logic [1:0] RATIO_DIV2    = 2'd1;
   localparam logic [1:0] RATIO_DIV4    = 2'd2;
   localparam logic [1:0] RATIO_DIV8    = 2'd3;

   // Maps a measured period (in clk cycles) onto the divide-ratio code.
   function automatic logic [1:0] ratio_for(input logic [31:0] p);
      case (p)
         32'd2:   return RATIO_DIV2;
         32'd4:   return RATIO_DIV4;
         32'd8:   return RATIO_DIV8;
         default: return RATIO_UNKNOWN;
      endcase
   endfunction

endpackage

// File: rtl/clkdiv_detect_edge.sv
// Single-register edge detector. rise/fall are combinational from the
// current input and its registered copy, so an edge is flagged in the
// same cycle the new level appears.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic q,
   output logic rise,
   output logic fall
);

   // Delayed copy of the input for edge comparison.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= 1'b0;
      else       q <= sig;
   end

   assign rise = sig & ~q;
   assign fall = ~sig & q;

endmodule

// File: rtl/clkdiv_detect.sv
// Measures the rise-to-rise period of a divided clock in clk cycles,
// declares lock once LOCK_COUNT consecutive periods agree, classifies
// div2/div4/div8 while locked, and times out when no edge arrives before
// the period counter would overflow.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no reference edge yet; waiting for the first rise
//   MEASURE | counting a period, not locked
//   LOCKED  | counting a period, last LOCK_COUNT periods were equal
module clkdiv_detect #(
   parameter int CNT_W      = 8,
   parameter int LOCK_COUNT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic [1:0]       ratio_code,
   output logic             timeout
);

   import clkdiv_detect_pkg::*;

   // Last count value that still leaves room for period = cnt + 1.
   localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [3:0]       LOCK_TGT = 4'(LOCK_COUNT);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [3:0]       match_cnt, match_next;
   logic [CNT_W-1:0] period_next;
   logic             pv_next, locked_next, timeout_next;
   logic [1:0]       ratio_next;

   logic             div_q, rise, fall;
   logic             unused_edge;

   logic [CNT_W-1:0] meas_period;
   logic [3:0]       match_upd;
   logic             lock_hit;
   logic             cnt_end;

   edge_detect u_rise (
      .clk   (clk),
      .reset (reset),
      .sig   (div_in),
      .q     (div_q),
      .rise  (rise),
      .fall  (fall)
   );

   // Only the rising edge drives this detector.
   assign unused_edge = div_q ^ fall;

   assign meas_period = cnt + 1'b1;
   assign cnt_end     = (cnt == CNT_LAST);

   // A repeated period extends the run (capped); anything else starts a new run of one.
   always_comb begin
      match_upd = 4'd1;
      if (meas_period == period)
         match_upd = (match_cnt >= LOCK_TGT) ? LOCK_TGT : match_cnt + 4'd1;
   end

   assign lock_hit = (match_upd >= LOCK_TGT);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; a rise wins over the counter-end timeout.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (rise) state_next = MEASURE;
         end
         MEASURE, LOCKED: begin
            if (rise)         state_next = lock_hit ? LOCKED : MEASURE;
            else if (cnt_end) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Next values for the counter, match tracker and registered outputs.
   always_comb begin
      cnt_next     = cnt;
      match_next   = match_cnt;
      period_next  = period;
      pv_next      = 1'b0;
      timeout_next = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise) cnt_next = '0;
         end
         MEASURE, LOCKED: begin
            if (rise) begin
               period_next = meas_period;
               pv_next     = 1'b1;
               cnt_next    = '0;
               match_next  = match_upd;
            end else if (cnt_end) begin
               timeout_next = 1'b1;
               cnt_next     = '0;
               match_next   = 4'd0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: begin
            cnt_next   = '0;
            match_next = 4'd0;
         end
      endcase
      locked_next = (state_next == LOCKED);
      ratio_next  = locked_next ? ratio_for(32'(period_next)) : RATIO_UNKNOWN;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         match_cnt    <= 4'd0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         ratio_code   <= RATIO_UNKNOWN;
         timeout      <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         match_cnt    <= match_next;
         period       <= period_next;
         period_valid <= pv_next;
         locked       <= locked_next;
         ratio_code   <= ratio_next;
         timeout      <= timeout_next;
      end
   end

endmodule

// File: tb/tb_clkdiv_detect.sv
// Scoreboard bench for clkdiv_detect (CNT_W=4, LOCK_COUNT=2). Stimulus
// pushes the hand-computed response for each rise or expected timeout;
// the monitor pops an entry whenever period_valid or timeout shows up.
module tb_clkdiv_detect;

   localparam int CNT_W      = 4;
   localparam int LOCK_COUNT = 2;

   logic             clk    = 1'b0;
   logic             reset  = 1'b1;
   logic             div_in = 1'b0;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic [1:0]       ratio_code;
   logic             timeout;

   typedef struct {
      bit is_to;
      int per;
      bit lk;
      int rc;
      int when;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_rise = 0;

   clkdiv_detect #(.CNT_W(CNT_W), .LOCK_COUNT(LOCK_COUNT)) dut (
      .clk          (clk),
      .reset        (reset),
      .div_in       (div_in),
      .period       (period),
      .period_valid (period_valid),
      .locked       (locked),
      .ratio_code   (ratio_code),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %0d, want %0d", name, cyc, act, req);
      end
   endtask

   // Monitor: every output event must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && (period_valid || timeout)) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event at cyc %0d: got pv=%0b to=%0b period=%0d, want nothing",
                     cyc, period_valid, timeout, period);
         end else begin
            e = sb.pop_front();
            check("kind",   {30'd0, period_valid, timeout}, e.is_to ? 32'd1 : 32'd2);
            check("period", 32'(period), e.per);
            check("locked", 32'(locked), 32'(e.lk));
            check("ratio",  32'(ratio_code), e.rc);
            check("cycle",  cyc, e.when);
         end
      end
   end

   task automatic drive(input logic v);
      @(posedge clk);
      #1 div_in = v;
   endtask

   // One div_in period: hi cycles high, lo low. The rise measures the
   // previous period; exp selects whether a period_valid is expected.
   task automatic per(input int hi, input int lo, input bit exp, input int p, input bit lk, input int rc);
      drive(1'b1);
      last_rise = cyc;
      if (exp) sb.push_back('{1'b0, p, lk, rc, cyc + 1});
      for (int i = 1; i < hi; i++) drive(1'b1);
      for (int i = 0; i < lo; i++) drive(1'b0);
   endtask

   // Counter reaches 2^CNT_W-2 fifteen cycles after the rise; pulse is registered one cycle later.
   task automatic expect_timeout(input int p);
      sb.push_back('{1'b1, p, 1'b0, 0, last_rise + (1 << CNT_W)});
   endtask

   task automatic hold_low(input int n);
      for (int i = 0; i < n; i++) drive(1'b0);
   endtask

   task automatic apply_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 reset = 1'b1;
         div_in = 1'b0;
      end
      @(negedge clk);
      check("rst_period",  32'(period), 0);
      check("rst_pv",      32'(period_valid), 0);
      check("rst_locked",  32'(locked), 0);
      check("rst_ratio",   32'(ratio_code), 0);
      check("rst_timeout", 32'(timeout), 0);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      apply_reset(3);

      // div_in toggling every cycle: period 2, lock and div2 from the second result
      per(1, 1, 0, 0, 0, 0);
      per(1, 1, 1, 2, 0, 0);
      per(1, 1, 1, 2, 1, 1);
      per(1, 1, 1, 2, 1, 1);
      per(1, 1, 1, 2, 1, 1);
      apply_reset(2);

      // period 8 locks as div8, then period 6 relocks with unknown ratio
      per(4, 4, 0, 0, 0, 0);
      per(4, 4, 1, 8, 0, 0);
      per(4, 4, 1, 8, 1, 3);
      per(3, 3, 1, 8, 1, 3);
      per(3, 3, 1, 6, 0, 0);
      per(3, 3, 1, 6, 1, 0);
      per(3, 3, 1, 6, 1, 0);
      apply_reset(2);

      // locked at 4, a period of 5 drops lock, repeated 5 relocks, then silence times out
      per(2, 2, 0, 0, 0, 0);
      per(2, 2, 1, 4, 0, 0);
      per(2, 2, 1, 4, 1, 2);
      per(3, 2, 1, 4, 1, 2);
      per(3, 2, 1, 5, 0, 0);
      per(3, 2, 1, 5, 1, 0);
      per(3, 2, 1, 5, 1, 0);
      expect_timeout(5);
      hold_low(20);

      // after timeout: first rise only re-arms; a rise at the last count value measures 15
      per(4, 4, 0, 0, 0, 0);
      per(4, 4, 1, 8, 0, 0);
      per(7, 8, 1, 8, 1, 3);
      per(4, 4, 1, 15, 0, 0);
      apply_reset(2);

      // reset three cycles into a period-8 measurement discards it
      per(4, 4, 0, 0, 0, 0);
      per(4, 4, 1, 8, 0, 0);
      per(3, 0, 1, 8, 1, 3);
      @(posedge clk);
      #1 reset = 1'b1;
      div_in = 1'b1;
      apply_reset(2);
      hold_low(2);
      per(4, 4, 0, 0, 0, 0);
      per(4, 4, 1, 8, 0, 0);
      expect_timeout(8);
      hold_low(20);

      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
